id_ex_stage: RTL

Pipeline register and operand-select stage between instruction decode and the 32-bit ALU. It captures one decoded instruction per cycle and translates opcode/funct into the ALU's 3-bit operation code. Each cycle it drives the ALU `a`/`b` inputs, forwarding results from the EX/MEM and MEM/WB latches where needed. It also supports stall, flush, and load-use hazard detection, so the ALU itself stays purely combinational.

---
 rtl/id_ex_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes opcode/funct into the ALU control code, holds the
// operands and forwards EX/MEM and MEM/WB results into the ALU inputs.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic        exmem_wr_en,
  input  logic        memwb_wr_en,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctr,
  output logic        ex_valid,
  output logic        ex_wr_en,
  output logic [4:0]  ex_rd,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic [1:0]  ex_branch,
  output logic        ex_illegal,
  output logic        load_use
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
    ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_NOR = 3'b110, ALU_NOT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {BR_NONE = 2'b00, BR_BEQ = 2'b01, BR_BNE = 2'b10} branch_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  alu_op_e     d_ctr;
  branch_e     d_branch;
  logic        d_legal, d_writes, d_use_imm, d_zext, d_load, d_store;
  logic [4:0]  d_dest;
  logic [31:0] d_imm;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    d_ctr     = ALU_ADD;
    d_branch  = BR_NONE;
    d_legal   = 1'b1;
    d_writes  = 1'b0;
    d_use_imm = 1'b0;
    d_zext    = 1'b0;
    d_load    = 1'b0;
    d_store   = 1'b0;
    d_dest    = id_rt;
    unique case (id_opcode)
      OP_RTYPE: begin
        d_dest   = id_rd;
        d_writes = 1'b1;
        case (id_funct)
          6'b100000, 6'b100001: d_ctr = ALU_ADD;
          6'b100010, 6'b100011: d_ctr = ALU_SUB;
          6'b100100:            d_ctr = ALU_AND;
          6'b100101:            d_ctr = ALU_OR;
          6'b100110:            d_ctr = ALU_XOR;
          6'b101010, 6'b101011: d_ctr = ALU_SLT;
          6'b100111:            d_ctr = ALU_NOR;
          default: begin
            d_legal  = 1'b0;
            d_writes = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin d_ctr = ALU_ADD; d_writes = 1'b1; d_use_imm = 1'b1; end
      OP_SLTI, OP_SLTIU: begin d_ctr = ALU_SLT; d_writes = 1'b1; d_use_imm = 1'b1; end
      OP_ANDI: begin d_ctr = ALU_AND; d_writes = 1'b1; d_use_imm = 1'b1; d_zext = 1'b1; end
      OP_ORI:  begin d_ctr = ALU_OR;  d_writes = 1'b1; d_use_imm = 1'b1; d_zext = 1'b1; end
      OP_XORI: begin d_ctr = ALU_XOR; d_writes = 1'b1; d_use_imm = 1'b1; d_zext = 1'b1; end
      OP_LW:   begin d_ctr = ALU_ADD; d_writes = 1'b1; d_use_imm = 1'b1; d_load = 1'b1; end
      OP_SW:   begin d_ctr = ALU_ADD; d_use_imm = 1'b1; d_store = 1'b1; end
      OP_BEQ:  begin d_ctr = ALU_SUB; d_branch = BR_BEQ; end
      OP_BNE:  begin d_ctr = ALU_SUB; d_branch = BR_BNE; end
      default: d_legal = 1'b0;
    endcase
  end

  assign d_imm = d_zext ? {16'h0000, id_imm} : {{16{id_imm[15]}}, id_imm};

  alu_op_e     ctr_q;
  logic [4:0]  rs_q, rt_q;
  logic [31:0] rs_data_q, rt_data_q, imm_q;
  logic        use_imm_q;
  logic [31:0] fwd_rs, fwd_rt;
  logic        rs_exmem, rs_memwb, rt_exmem, rt_memwb;

  // EX/MEM is the younger result, so it wins over MEM/WB; register 0 is never bypassed.
  assign rs_exmem = exmem_wr_en && (exmem_rd == rs_q) && (rs_q != 5'd0);
  assign rs_memwb = memwb_wr_en && (memwb_rd == rs_q) && (rs_q != 5'd0);
  assign rt_exmem = exmem_wr_en && (exmem_rd == rt_q) && (rt_q != 5'd0);
  assign rt_memwb = memwb_wr_en && (memwb_rd == rt_q) && (rt_q != 5'd0);

  assign fwd_rs = rs_exmem ? exmem_result : (rs_memwb ? memwb_result : rs_data_q);
  assign fwd_rt = rt_exmem ? exmem_result : (rt_memwb ? memwb_result : rt_data_q);

  assign alu_a   = fwd_rs;
  assign alu_b   = use_imm_q ? imm_q : fwd_rt;
  assign alu_ctr = ctr_q;

  assign load_use = ex_valid && ex_mem_rd && id_valid && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

  // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_rd      <= 5'd0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
      ex_branch  <= BR_NONE;
      ex_illegal <= 1'b0;
      ctr_q      <= ALU_ADD;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rs_data_q  <= 32'd0;
      rt_data_q  <= 32'd0;
      imm_q      <= 32'd0;
      use_imm_q  <= 1'b0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
      ex_branch  <= BR_NONE;
      ex_illegal <= 1'b0;
    end else if (stall) begin
      // Latch the bypassed values so a result retiring from MEM/WB mid-stall is not lost.
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
    end else begin
      ex_valid   <= id_valid;
      ex_wr_en   <= id_valid && d_writes && (d_dest != 5'd0);
      ex_rd      <= d_dest;
      ex_mem_rd  <= id_valid && d_load;
      ex_mem_wr  <= id_valid && d_store;
      ex_branch  <= id_valid ? d_branch : BR_NONE;
      ex_illegal <= id_valid && !d_legal;
      ctr_q      <= d_ctr;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_q      <= d_imm;
      use_imm_q  <= d_use_imm;
    end
  end

endmodule
